seg_scan_mux: RTL

//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
//  - Scans NUM_DIGITS hex digits at a programmable slot rate.
//  - Inserts an all-off blanking gap between digits to prevent ghosting.
//  - Supports per-digit decimal points and leading-zero blanking.
//  - Sits between score/status logic and the board's SEG/ENABLE pins.

---
 rtl/seg_disp_pkg.sv | 25 ++
 rtl/seg_hex_font.sv | 11 +
 rtl/seg_scan_mux.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared font table, blank pattern and scan FSM encoding for the 7-segment driver
package seg_disp_pkg;

  // Scan slot phases: all-off gap, then the selected digit lit
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } seg_state_e;

  // Active-low segment byte with every segment and the dp dark
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low hex font, bit 7 (dp) held off, bits [6:0] = g..a
  localparam logic [7:0] SEG_FONT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [6:0] font_lookup(input logic [3:0] value);
    logic [7:0] glyph;
    glyph = SEG_FONT[value];
    return glyph[6:0];
  endfunction

endpackage

// File: rtl/seg_hex_font.sv
// rtl/seg_hex_font.sv - combinational 4-bit hex value to active-low g..a segment pattern
module seg_hex_font
  import seg_disp_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = font_lookup(value_i);

endmodule

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed N-digit common-anode 7-segment scanner; SEG_DIM_EN adds PWM brightness
module seg_scan_mux
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
`ifdef SEG_DIM_EN
  input  logic [3:0]                bright_i,
`endif
  output logic [7:0]                seg_o,
  output logic [NUM_DIGITS-1:0]     enable_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  seg_state_e            state_q, state_d;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] enable_q;

  logic                  wrap;
  logic                  load;
  logic                  lit;

  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [3:0]            sel_digit;
  logic                  sel_dp;
  logic                  sel_lz;
  logic [NUM_DIGITS-1:0] en_n;
  logic [6:0]            font_seg;
  logic [7:0]            show_seg;

  // Slot counter, digit index and next phase; load marks the edge that opens a lit slot
  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    state_d = (int'(cnt_d) < BLANK_CYCLES) ? BLANK : SHOW;
    load    = (state_d == SHOW) && ((state_q == BLANK) || wrap);
  end

  // Leading-zero mask: digit d>0 dark when it and every higher digit is zero
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      zero_run   = zero_run & (digits_i[4*d +: 4] == 4'h0);
      lz_mask[d] = zero_run & (LZ_BLANK != 0);
    end
  end

  // Pick value, dp and blanking of the digit entering the next slot, plus its anode pattern
  always_comb begin
    sel_digit = 4'h0;
    sel_dp    = 1'b0;
    sel_lz    = 1'b0;
    en_n      = '1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (idx_d == IDX_W'(d)) begin
        sel_digit = digits_i[4*d +: 4];
        sel_dp    = dp_i[d];
        sel_lz    = lz_mask[d];
        en_n[d]   = 1'b0;
      end
    end
  end

  seg_hex_font u_font (
    .value_i (sel_digit),
    .seg_n_o (font_seg)
  );

  assign show_seg = {~sel_dp, sel_lz ? 7'h7F : font_seg};

`ifdef SEG_DIM_EN
  logic [3:0] pwm_q;
  logic [3:0] pwm_d;
  logic [3:0] bright_q;
  logic [3:0] bright_d;

  // Brightness is frozen with the digit snapshot; the anode is gated by the free-running PWM phase
  always_comb begin
    pwm_d    = pwm_q + 4'd1;
    bright_d = load ? bright_i : bright_q;
    lit      = (pwm_d <= bright_d);
  end

  // Free-running PWM counter and captured brightness
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pwm_q    <= 4'd0;
      bright_q <= 4'd0;
    end else begin
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
    end
  end
`else
  assign lit = 1'b1;
`endif

  // Scan FSM with registered pins; SEG is captured only when a lit slot opens
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= BLANK;
      seg_q    <= SEG_OFF;
      enable_q <= '1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      case (state_d)
        BLANK: begin
          seg_q    <= SEG_OFF;
          enable_q <= '1;
        end
        SHOW: begin
          if (load) begin
            seg_q <= show_seg;
          end
          enable_q <= lit ? en_n : '1;
        end
        default: begin
          seg_q    <= SEG_OFF;
          enable_q <= '1;
        end
      endcase
    end
  end

  assign seg_o    = seg_q;
  assign enable_o = enable_q;

endmodule
